// File: rtl/gs_cfg_ctrl.sv
// FPGA configuration controller for the GS CPLD: Z80 I/O port decode, nCONFIG
// sequencing with a minimum low pulse and nSTATUS timeout, sticky cold-reset flag.
module gs_cfg_ctrl #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] CTRL_PORT = 8'h80,
    parameter logic [ADDR_W-1:0] FLAG_PORT = 8'h40,
    parameter logic [ADDR_W-1:0] CS_PORT   = 8'hC0,
    parameter int                PULSE_CYC = 8,
    parameter int                TMO_W     = 16,
    parameter int                TMO_CYC   = 50000
) (
    input  logic              clkin,
    input  logic              coldres_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              dout_oe,
    output logic              cs,
    output logic              config_n,
    input  logic              status_n,
    input  logic              conf_done,
    input  logic              init_done,
    output logic              cold_flag,
    output logic              cfg_err
);

    localparam int              PC_W      = $clog2(PULSE_CYC + 1);
    localparam logic [PC_W-1:0] PULSE_MAX = PC_W'(PULSE_CYC);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_CYC);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pulse_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_status_meta, r_status_s;
    logic               r_conf_meta, r_conf_s;
    logic               r_init_meta, r_init_s;
    logic               r_iow_d;
    logic               r_req;

    logic               w_iow;
    logic               w_wr_accept;
    logic               w_ctrl_hit;
    logic               w_flag_hit;
    logic [PC_W-1:0]    w_pulse_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic [7:0]         w_rd_data;
    logic               w_unused_din;

    // Bus decode, counter increments and read-data mux.
    always_comb begin
        w_iow        = !iorq_n && !wr_n;
        w_wr_accept  = w_iow && !r_iow_d;
        w_ctrl_hit   = (addr == CTRL_PORT);
        w_flag_hit   = (addr == FLAG_PORT);
        dout_oe      = !iorq_n && !rd_n && (w_ctrl_hit || w_flag_hit);
        cs           = (addr == CS_PORT);
        w_unused_din = ^din[6:1];
        w_tmo_nxt    = r_tmo_cnt + TMO_W'(1);
        if (r_pulse_cnt == PULSE_MAX) begin
            w_pulse_nxt = PULSE_MAX;
        end else begin
            w_pulse_nxt = r_pulse_cnt + PC_W'(1);
        end
        if (w_ctrl_hit) begin
            w_rd_data = {r_status_s, cfg_err, r_init_s, 2'b00,
                         (r_state == ST_READY), config_n, r_conf_s};
        end else if (w_flag_hit) begin
            w_rd_data = {cold_flag, 7'b0000000};
        end else begin
            w_rd_data = 8'h00;
        end
    end

    // Two-flop synchronisers for the asynchronous FPGA status pins.
    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            r_status_meta <= 1'b1;
            r_status_s    <= 1'b1;
            r_conf_meta   <= 1'b0;
            r_conf_s      <= 1'b0;
            r_init_meta   <= 1'b0;
            r_init_s      <= 1'b0;
        end else begin
            r_status_meta <= status_n;
            r_status_s    <= r_status_meta;
            r_conf_meta   <= conf_done;
            r_conf_s      <= r_conf_meta;
            r_init_meta   <= init_done;
            r_init_s      <= r_init_meta;
        end
    end

    // Register file: one accepted write per bus cycle; cold_flag only set here.
    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            r_iow_d   <= 1'b0;
            r_req     <= 1'b0;
            cold_flag <= 1'b0;
            dout      <= 8'h00;
        end else begin
            r_iow_d <= w_iow;
            dout    <= w_rd_data;
            if (w_wr_accept && w_ctrl_hit) begin
                r_req <= din[0];
                if (din[7]) begin
                    cold_flag <= 1'b1;
                end
            end
        end
    end

    // Configuration sequencer; the HOLD release fires on the edge the count reaches
    // PULSE_CYC so config_n is low for exactly PULSE_CYC cycles after HOLD entry.
    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            r_state     <= ST_HOLD;
            r_pulse_cnt <= {PC_W{1'b0}};
            r_tmo_cnt   <= {TMO_W{1'b0}};
            config_n    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_pulse_cnt <= w_pulse_nxt;
                    if (r_req && (w_pulse_nxt == PULSE_MAX)) begin
                        r_state   <= ST_WAIT;
                        r_tmo_cnt <= {TMO_W{1'b0}};
                        config_n  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!r_req) begin
                        r_state     <= ST_HOLD;
                        r_pulse_cnt <= {PC_W{1'b0}};
                        config_n    <= 1'b0;
                        cfg_err     <= 1'b0;
                    end else if (r_status_s) begin
                        r_state <= ST_READY;
                    end else if (w_tmo_nxt == TMO_MAX) begin
                        r_state <= ST_ERR;
                        cfg_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= w_tmo_nxt;
                    end
                end
                ST_READY: begin
                    if (!r_req) begin
                        r_state     <= ST_HOLD;
                        r_pulse_cnt <= {PC_W{1'b0}};
                        config_n    <= 1'b0;
                        cfg_err     <= 1'b0;
                    end else if (!r_status_s) begin
                        r_state <= ST_ERR;
                        cfg_err <= 1'b1;
                    end
                end
                ST_ERR: begin
                    if (!r_req) begin
                        r_state     <= ST_HOLD;
                        r_pulse_cnt <= {PC_W{1'b0}};
                        config_n    <= 1'b0;
                        cfg_err     <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_HOLD;
                    r_pulse_cnt <= {PC_W{1'b0}};
                    config_n    <= 1'b0;
                    cfg_err     <= 1'b0;
                end
            endcase
        end
    end

endmodule
